// File: rtl/btn_sequencer.sv
// Scripted controller-button player: steps through a DEPTH-entry script of {hold, btns}
// words, one frame tick at a time. Define BTN_SEQ_LOOP_EN to wrap to entry 0 at end of script.
module btn_sequencer #(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          new_frame,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  output logic [7:0]    btns,
  output logic [AW-1:0] entry,
  output logic [15:0]   frame_cnt,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t      state;
  logic [15:0] mem [DEPTH];
  logic [7:0]  remaining;
  logic [AW-1:0] nxt;
  logic [15:0] first_word, nxt_word;
  logic        last;

  // Script storage survives reset so a script can be replayed after an abort.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign first_word = mem[0];
  assign nxt        = entry + AW'(1);
  assign nxt_word   = mem[nxt];
  assign last       = (entry == AW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      btns      <= 8'h00;
      entry     <= '0;
      frame_cnt <= 16'h0000;
      remaining <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      // start wins over any same-cycle frame tick, in every state
      entry     <= '0;
      frame_cnt <= 16'h0000;
      remaining <= first_word[15:8];
      if (first_word[15:8] == 8'h00) begin
        state <= DONE;
        btns  <= 8'h00;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= PLAY;
        btns  <= first_word[7:0];
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else if (state == PLAY && new_frame) begin
      if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (remaining > 8'd1) begin
        remaining <= remaining - 8'd1;
      end else if (!last && nxt_word[15:8] != 8'h00) begin
        entry     <= nxt;
        remaining <= nxt_word[15:8];
        btns      <= nxt_word[7:0];
      end else begin
`ifdef BTN_SEQ_LOOP_EN
        if (first_word[15:8] != 8'h00) begin
          entry     <= '0;
          remaining <= first_word[15:8];
          btns      <= first_word[7:0];
        end else begin
          // entry 0 was cleared mid-play: nothing left to loop over
          state     <= DONE;
          btns      <= 8'h00;
          remaining <= 8'h00;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
`else
        state     <= DONE;
        btns      <= 8'h00;
        remaining <= 8'h00;
        busy      <= 1'b0;
        done      <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_btn_sequencer.sv
// Directed bench for btn_sequencer (DEPTH=8); expected values are hand-derived per step.
module tb_btn_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, new_frame = 1'b0, wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [15:0]   wr_data = 16'h0000;
  logic [7:0]    btns;
  logic [AW-1:0] entry;
  logic [15:0]   frame_cnt;
  logic          busy, done;
  int            errors = 0, checks = 0;

  btn_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .new_frame(new_frame), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .btns(btns), .entry(entry),
    .frame_cnt(frame_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic frame();
    new_frame = 1'b1; cyc(); new_frame = 1'b0; cyc();
  endtask

  task automatic chk_all(input string tag, input logic [7:0] b, input logic [AW-1:0] e,
                         input logic [15:0] fc, input logic bz, input logic dn);
    chk({tag, ".btns"}, 32'(btns), 32'(b));
    chk({tag, ".entry"}, 32'(entry), 32'(e));
    chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(fc));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  initial begin
    // reset state, and frame ticks ignored in IDLE
    cyc(); cyc();
    chk_all("reset", 8'h00, 0, 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc();
    frame();
    chk_all("idle_frame", 8'h00, 0, 16'd0, 1'b0, 1'b0);

    // basic script: 0x08 for 2 frames, 0x01 for 3 frames, then done
    wr(0, 16'h0208); wr(1, 16'h0301); wr(2, 16'h0000);
    do_start();
    chk_all("basic_start", 8'h08, 0, 16'd0, 1'b1, 1'b0);
    frame();
    chk_all("basic_f1", 8'h08, 0, 16'd1, 1'b1, 1'b0);
    frame();
    chk_all("basic_f2", 8'h01, 1, 16'd2, 1'b1, 1'b0);
    frame(); frame();
    chk_all("basic_f4", 8'h01, 1, 16'd4, 1'b1, 1'b0);
    frame();
    chk("basic_f5.btns", 32'(btns), 32'h00);
    chk("basic_f5.done", 32'(done), 32'd1);
    chk("basic_f5.busy", 32'(busy), 32'd0);
    chk("basic_f5.fc", 32'(frame_cnt), 32'd5);
    frame();
    chk("basic_f6.fc", 32'(frame_cnt), 32'd5);
    chk("basic_f6.done", 32'(done), 32'd1);

    // empty script
    wr(0, 16'h0000);
    do_start();
    chk_all("empty", 8'h00, 0, 16'd0, 1'b0, 1'b1);

    // start and new_frame together mid-play
    wr(0, 16'h0304); wr(1, 16'h0220); wr(2, 16'h0000);
    do_start();
    frame(); frame(); frame(); frame();
    chk_all("restart_pre", 8'h20, 1, 16'd4, 1'b1, 1'b0);
    start = 1'b1; new_frame = 1'b1; cyc(); start = 1'b0; new_frame = 1'b0;
    chk_all("restart", 8'h04, 0, 16'd0, 1'b1, 1'b0);
    frame(); frame();
    chk("restart_rem2.entry", 32'(entry), 32'd0);
    frame();
    chk("restart_rem3.entry", 32'(entry), 32'd1);

    // overwrite the current entry mid-hold; same-cycle write/read of next entry
    wr(0, 16'h0510); wr(1, 16'h0140); wr(2, 16'h0000);
    do_start();
    frame();
    chk("ovw_f1.btns", 32'(btns), 32'h10);
    wr(0, 16'h0180);
    frame();
    chk("ovw_f2.btns", 32'(btns), 32'h10);
    frame();
    chk("ovw_f3.btns", 32'(btns), 32'h10);
    frame();
    chk("ovw_f4.btns", 32'(btns), 32'h10);
    chk("ovw_f4.entry", 32'(entry), 32'd0);
    new_frame = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h0302;
    cyc();
    new_frame = 1'b0; wr_en = 1'b0;
    cyc();
    chk("ovw_f5.btns", 32'(btns), 32'h40);
    chk("ovw_f5.entry", 32'(entry), 32'd1);
    frame();
    chk("ovw_oldhold.done", 32'(done), 32'd1);

    // async reset between edges mid-play, then replay
    wr(0, 16'h0201); wr(1, 16'h0102); wr(2, 16'h0000);
    do_start();
    frame();
    #3 rst = 1'b1;
    #1 chk_all("async_rst", 8'h00, 0, 16'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    cyc();
    do_start();
    chk_all("replay_start", 8'h01, 0, 16'd0, 1'b1, 1'b0);
    frame(); frame();
    chk_all("replay_f2", 8'h02, 1, 16'd2, 1'b1, 1'b0);
    frame();
    chk("replay_f3.done", 32'(done), 32'd1);

    // full script of single-frame entries
    for (int i = 0; i < DEPTH; i++) wr(i, {8'h01, 8'(i + 1)});
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full_e%0d.entry", i), 32'(entry), 32'(i));
      chk($sformatf("full_e%0d.btns", i), 32'(btns), 32'(i + 1));
      frame();
    end
    chk("full_end.fc", 32'(frame_cnt), 32'(DEPTH));
`ifdef BTN_SEQ_LOOP_EN
    chk("full_end.entry", 32'(entry), 32'd0);
    chk("full_end.busy", 32'(busy), 32'd1);
`else
    chk("full_end.done", 32'(done), 32'd1);
    chk("full_end.busy", 32'(busy), 32'd0);
    chk("full_end.btns", 32'(btns), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/btn_sequencer.md
BTN_SEQUENCER -- requirements
Module: btn_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of script entries (power of two, 4..256).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), entry index width.
REQ-003 SHALL have port clk  input  1  single clock for all logic (CPU clock domain).
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begin playback from entry 0.
REQ-006 SHALL have port new_frame  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port wr_en  input  1  script write strobe.
REQ-008 SHALL have port wr_addr  input  AW  script entry written.
REQ-009 SHALL have port wr_data  input  16  {hold[15:8], btns[7:0]}; hold = frames the entry is held.
REQ-010 SHALL have port btns  output  8  button state to controller model, bit order A,B,SELECT,START,UP,DOWN,LEFT,RIGHT (bit0..7), 1 = pressed.
REQ-011 SHALL have port entry  output  AW  index of current entry.
REQ-012 SHALL have port frame_cnt  output  16  frames elapsed since start.
REQ-013 SHALL have port busy  output  1  high in PLAY.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL hold the script in a DEPTH x 16 register file, asynchronous read, written on clk when wr_en in any state.
REQ-016 SHALL implement states IDLE, PLAY, DONE.
REQ-017 IDLE/DONE: btns = 0x00; start -> PLAY, entry = 0, remaining = hold[0], frame_cnt = 0.
REQ-018 SHALL go directly to DONE on start if hold[0] == 0 (empty script).
REQ-019 PLAY: btns = registered btns field of current entry, valid the cycle after the entry is loaded.
REQ-020 PLAY, on new_frame: frame_cnt += 1 (saturating at 0xFFFF); if remaining > 1, remaining -= 1.
REQ-021 PLAY, on new_frame with remaining == 1: advance to entry+1 and load its hold; if entry == DEPTH-1 or next hold == 0, end of script.
REQ-022 End of script SHALL enter DONE, btns = 0x00 on the following cycle, done = 1.
REQ-023 start in PLAY SHALL restart from entry 0 and clear frame_cnt; start wins over simultaneous new_frame.
REQ-024 Write to the current entry during PLAY SHALL NOT alter btns or remaining until that entry is reloaded.
REQ-025 Write and read of the same entry in one cycle SHALL return the old data.
REQ-026 new_frame in IDLE/DONE SHALL be ignored; frame_cnt holds.

Reset
REQ-027 rst SHALL asynchronously force IDLE, btns = 0, entry = 0, frame_cnt = 0, remaining = 0, busy = 0, done = 0.
REQ-028 Script storage SHALL NOT be cleared by rst; rst mid-PLAY aborts playback, and the script is replayable by start.

Configuration
REQ-029 Macro BTN_SEQ_LOOP_EN: when defined, end of script SHALL wrap to entry 0 (reload hold[0], frame_cnt keeps counting) and stay in PLAY; DONE is unreachable except via an empty script.
REQ-030 Without BTN_SEQ_LOOP_EN, end of script SHALL enter DONE per REQ-022.

Verification
REQ-031 Script {0x02_08, 0x03_01, 0x00_00}, start, 6 new_frame pulses -> btns 0x08 for 2 frames, 0x01 for 3 frames, then 0x00, done = 1, frame_cnt = 5.
REQ-032 Entry 0 = 0x0000, start -> done = 1 next cycle, btns = 0x00, busy = 0.
REQ-033 Full script of DEPTH entries each 0x01_xx, DEPTH frames -> entry steps 0..DEPTH-1, then DONE (loop macro off) or entry = 0, busy = 1 (loop macro on).
REQ-034 start and new_frame in the same cycle mid-PLAY -> entry = 0, frame_cnt = 0, remaining = hold[0].
REQ-035 Async rst pulse between clock edges mid-PLAY -> all outputs 0 immediately; subsequent start replays the unchanged script.
REQ-036 Overwrite the current entry 0x05_10 with 0x01_80 mid-hold -> btns stays 0x10 for all 5 frames.
